pc_fetch_unit: RTL and testbench

- Parametrised program-counter generator for the fetch stage of the pipelined core.
- Holds the architectural fetch PC and produces the sequential next address.
- Accepts branch/jump redirects from EX and trap redirects from the exception logic.
- Supports stall, halt/resume and a valid/ready handshake toward instruction memory.

---
 rtl/pc_fetch_unit.sv | 81 ++++++++
 tb/tb_pc_fetch_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage PC generator with redirects, traps, stall, halt/resume; optional PC_COMPRESSED_EN adds 16-bit instruction stepping.
module pc_fetch_unit #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          INC          = 4,
  parameter int          ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [WIDTH-1:0] redirect_target_i,
  input  logic             trap_valid_i,
  input  logic [WIDTH-1:0] trap_target_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  input  logic             fetch_ready_i,
`ifdef PC_COMPRESSED_EN
  input  logic [1:0]       instr_lo_i,
`endif
  output logic             fetch_valid_o,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus_o,
  output logic             misalign_o,
  output logic [1:0]       state_o
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2, BAD = 2'd3} state_t;
`ifdef PC_COMPRESSED_EN
  localparam int AB = 1;
`else
  localparam int AB = ALIGN_BITS;
`endif
  localparam logic [WIDTH-1:0] LOW = ~({WIDTH{1'b1}} << AB);
  state_t           state, state_n;
  logic [WIDTH-1:0] pc_n, inc, trap_pc;
  logic             mis_n, rd_ok, rd_bad, adv;
`ifdef PC_COMPRESSED_EN
  assign inc = (instr_lo_i != 2'b11) ? WIDTH'(2) : WIDTH'(INC);
`else
  assign inc = WIDTH'(INC);
`endif
  assign pc_plus_o     = pc_o + inc;
  assign trap_pc       = trap_target_i & ~LOW;
  assign rd_ok         = redirect_valid_i && ((redirect_target_i & LOW) == '0);
  assign rd_bad        = redirect_valid_i && !rd_ok;
  assign adv           = fetch_ready_i && !stall_i;
  assign fetch_valid_o = (state == RUN);
  assign state_o       = state;
  // a trap always wins and silences any misalign report from the same cycle
  always_comb begin
    state_n = state;
    pc_n    = pc_o;
    mis_n   = 1'b0;
    case (state)
      BOOT: state_n = RUN;
      RUN: begin
        pc_n    = trap_valid_i ? trap_pc : rd_ok ? redirect_target_i
                : (!redirect_valid_i && adv) ? pc_plus_o : pc_o;
        mis_n   = !trap_valid_i && rd_bad;
        state_n = (!trap_valid_i && halt_req_i) ? HALT : RUN;
      end
      HALT: begin
        pc_n    = trap_valid_i ? trap_pc : rd_ok ? redirect_target_i : pc_o;
        mis_n   = !trap_valid_i && rd_bad;
        state_n = (trap_valid_i || resume_i) ? RUN : HALT;
      end
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc_o       <= WIDTH'(RESET_VECTOR);
      misalign_o <= 1'b0;
    end else begin
      state      <= state_n;
      pc_o       <= pc_n;
      misalign_o <= mis_n;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scoreboard bench for pc_fetch_unit with RESET_VECTOR=0x1000.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, rv, tv, halt, resume, ready;
  logic [31:0] rt, tt;
  logic [1:0]  instr_lo = 2'b11;
  logic        fv, mis;
  logic [31:0] pc, pc_plus;
  logic [1:0]  st;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    logic [31:0] pc;
    logic        mis;
    logic [1:0]  st;
    logic [31:0] pc_plus;
  } exp_t;
  exp_t q[$];

  pc_fetch_unit #(.WIDTH(32), .RESET_VECTOR(32'h1000), .INC(4), .ALIGN_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall),
    .redirect_valid_i(rv), .redirect_target_i(rt),
    .trap_valid_i(tv), .trap_target_i(tt),
    .halt_req_i(halt), .resume_i(resume), .fetch_ready_i(ready),
`ifdef PC_COMPRESSED_EN
    .instr_lo_i(instr_lo),
`endif
    .fetch_valid_o(fv), .pc_o(pc), .pc_plus_o(pc_plus),
    .misalign_o(mis), .state_o(st)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inc_of(input logic [1:0] lo);
`ifdef PC_COMPRESSED_EN
    return (lo != 2'b11) ? 32'd2 : 32'd4;
`else
    return 32'd4;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_now(input string tag, input exp_t e);
    chk({tag, ".pc"}, pc, e.pc);
    chk({tag, ".pc_plus"}, pc_plus, e.pc_plus);
    chk({tag, ".misalign"}, {31'd0, mis}, {31'd0, e.mis});
    chk({tag, ".state"}, {30'd0, st}, {30'd0, e.st});
    chk({tag, ".fetch_valid"}, {31'd0, fv}, {31'd0, e.st == 2'd1});
  endtask

  // drive one cycle of stimulus, queue its expected outcome, compare after the edge
  task automatic step(input string tag, input logic s, input logic r, input logic [31:0] rtg,
                      input logic t, input logic [31:0] ttg, input logic h, input logic rs,
                      input logic rdy, input logic [31:0] epc, input logic em, input logic [1:0] est);
    exp_t e;
    stall = s; rv = r; rt = rtg; tv = t; tt = ttg; halt = h; resume = rs; ready = rdy;
    e.pc = epc; e.mis = em; e.st = est; e.pc_plus = epc + inc_of(instr_lo);
    q.push_back(e);
    @(posedge clk); #1;
    check_now(tag, q.pop_front());
  endtask

  initial begin
    exp_t e;
    stall = 0; rv = 0; rt = 0; tv = 0; tt = 0; halt = 0; resume = 0; ready = 1;
    @(posedge clk); #1;
    e = '{32'h1000, 1'b0, 2'd0, 32'h1004};
    check_now("reset", e);
    rst_n = 1'b1;
    check_now("boot", e);
    //    tag         stl rv rt            tv tt            hlt rsm rdy exp_pc        mis st
    step("boot_exit", 0, 0, 0,            0, 0,            0,  0,  1,  32'h1000,     0,  1);
    step("seq1",      0, 0, 0,            0, 0,            0,  0,  1,  32'h1004,     0,  1);
    step("seq2",      0, 0, 0,            0, 0,            0,  0,  1,  32'h1008,     0,  1);
    step("stall1",    1, 0, 0,            0, 0,            0,  0,  1,  32'h1008,     0,  1);
    step("stall2",    1, 0, 0,            0, 0,            0,  0,  1,  32'h1008,     0,  1);
    step("stall3",    1, 0, 0,            0, 0,            0,  0,  1,  32'h1008,     0,  1);
    step("redir_stl", 1, 1, 32'h2000,     0, 0,            0,  0,  1,  32'h2000,     0,  1);
    step("not_ready", 0, 0, 0,            0, 0,            0,  0,  0,  32'h2000,     0,  1);
    step("trap_wins", 0, 1, 32'h3000,     1, 32'h83,       0,  0,  0,  32'h80,       0,  1);
    step("misalign",  0, 1, 32'h3002,     0, 0,            0,  0,  1,  32'h80,       1,  1);
    step("mis_clear", 0, 0, 0,            0, 0,            0,  0,  0,  32'h80,       0,  1);
    step("trap_supp", 0, 1, 32'h3002,     1, 32'h40,       0,  0,  0,  32'h40,       0,  1);
    step("redir",     0, 1, 32'h2000,     0, 0,            0,  0,  0,  32'h2000,     0,  1);
    step("halt_adv",  0, 0, 0,            0, 0,            1,  0,  1,  32'h2004,     0,  2);
    step("halt_hold", 0, 0, 0,            0, 0,            0,  0,  1,  32'h2004,     0,  2);
    step("halt_redir",0, 1, 32'h4000,     0, 0,            0,  0,  1,  32'h4000,     0,  2);
    step("halt_mis",  0, 1, 32'h4001,     0, 0,            0,  0,  1,  32'h4000,     1,  2);
    step("resume",    0, 0, 0,            0, 0,            1,  1,  1,  32'h4000,     0,  1);
    step("post_res",  0, 0, 0,            0, 0,            0,  0,  1,  32'h4004,     0,  1);
    step("halt2",     0, 0, 0,            0, 0,            1,  0,  1,  32'h4008,     0,  2);
    step("halt_trap", 0, 0, 0,            1, 32'h102,      0,  0,  1,  32'h100,      0,  1);
    step("trap_halt", 0, 0, 0,            1, 32'h200,      1,  0,  1,  32'h200,      0,  1);
    step("to_top",    0, 1, 32'hFFFF_FFFC,0, 0,            0,  0,  0,  32'hFFFF_FFFC,0,  1);
    step("wrap",      0, 0, 0,            0, 0,            0,  0,  1,  32'h0,        0,  1);
    step("after_wrap",0, 0, 0,            0, 0,            0,  0,  1,  32'h4,        0,  1);
`ifdef PC_COMPRESSED_EN
    step("c_redir",   0, 1, 32'h100,      0, 0,            0,  0,  0,  32'h100,      0,  1);
    instr_lo = 2'b01;
    step("c_half",    0, 0, 0,            0, 0,            0,  0,  1,  32'h102,      0,  1);
    instr_lo = 2'b11;
    step("c_full",    0, 0, 0,            0, 0,            0,  0,  1,  32'h106,      0,  1);
    step("c_odd2",    0, 1, 32'h202,      0, 0,            0,  0,  0,  32'h202,      0,  1);
    step("c_trap",    0, 0, 0,            1, 32'h303,      0,  0,  0,  32'h302,      0,  1);
`endif
    stall = 0; rv = 0; tv = 0; halt = 0; resume = 0; ready = 1;
    #2 rst_n = 1'b0;
    #1;
    e = '{32'h1000, 1'b0, 2'd0, 32'h1000 + inc_of(instr_lo)};
    check_now("async_rst", e);
    @(posedge clk); #1;
    check_now("rst_held", e);
    rst_n = 1'b1;
    step("reboot",    0, 0, 0,            0, 0,            0,  0,  1,  32'h1000,     0,  1);
    step("reboot_seq",0, 0, 0,            0, 0,            0,  0,  1,  32'h1004,     0,  1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
